// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file debug dump reader.
package regfile_dump_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks a register-address range through a synchronous read port and streams
// each (address, value) pair out on a valid/ready handshake.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    end_d      = end_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          cnt_d   = first_addr;
          end_d   = last_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          out_data_d = rf_rdata;
          out_addr_d = cnt_q;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (cnt_q == end_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      end_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  // The counter only changes on start or handshake, so it doubles as the held read address.
  assign rf_raddr  = cnt_q;
  assign out_valid = (state_q == VALID);
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump against a queue-based range model.
module tb_regfile_dump;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, out_ready;
  logic [AW-1:0] first_addr, last_addr, rf_raddr, out_addr;
  logic [DW-1:0] rf_rdata, out_data;
  logic          out_valid, busy, done;

  logic [DW-1:0] rf_mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  // Register file read port: synchronous read, x0 hardwired to zero.
  always @(posedge clk) rf_rdata <= (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input int a);
    return (a == 0) ? 32'd0 : rf_mem[a];
  endfunction

  // Drive one dump and score every handshake against the expected address list.
  task automatic run_dump(input int first, input int last, input int ready_pct, input bit poke_start);
    int            exp_q[$];
    int            a, total, n_pairs, done_cyc, budget;
    bit            stalled, got_done;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    a = first;
    forever begin
      exp_q.push_back(a);
      if (a == last) break;
      a = (a + 1) % 32;
    end
    total    = exp_q.size();
    n_pairs  = 0;
    done_cyc = 0;
    got_done = 0;
    stalled  = 0;
    hold_a   = '0;
    hold_d   = '0;
    budget   = total * 3 + 400;

    @(negedge clk);
    first_addr = AW'(first);
    last_addr  = AW'(last);
    start      = 1'b1;
    out_ready  = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk("issue_raddr", 32'(rf_raddr), 32'(first));
        chk("issue_busy", 32'(busy), 32'd1);
        chk("issue_valid", 32'(out_valid), 32'd0);
      end
      if (ready_pct == 100 && c == 3) chk("valid_latency", 32'(out_valid), 32'd1);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_addr", 32'(out_addr), 32'(hold_a));
        chk("stall_data", out_data, hold_d);
      end
      if (done) begin
        got_done = 1;
        done_cyc = c;
        chk("done_busy", 32'(busy), 32'd0);
        break;
      end
      if (poke_start && c == 4) begin
        start      = 1'b1;
        first_addr = AW'($urandom_range(31));
      end else if (poke_start && c == 5) begin
        start      = 1'b0;
        first_addr = AW'(first);
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_pair", 32'(n_pairs + 1), 32'(total));
        end else begin
          a = exp_q.pop_front();
          chk("pair_addr", 32'(out_addr), 32'(a));
          chk("pair_data", out_data, reg_val(a));
        end
        n_pairs++;
      end
      stalled = out_valid && !out_ready;
      hold_a  = out_addr;
      hold_d  = out_data;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("pair_count", 32'(n_pairs), 32'(total));
    if (ready_pct == 100) chk("done_cycle", 32'(done_cyc), 32'(3 * total + 1));
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_raddr"}, 32'(rf_raddr), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_oaddr"}, 32'(out_addr), 32'd0);
    chk({tag, "_odata"}, out_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  n;
    bit  saw_bad;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rf_mem[0]  = 32'hDEAD_BEEF;
    rf_mem[8]  = 32'd1;
    rf_mem[9]  = 32'd2;
    rf_mem[18] = 32'd3;
    rf_mem[19] = 32'd4;
    rf_mem[20] = 32'd5;
    rf_mem[21] = 32'd6;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run_dump(0, 31, 100, 0);
    run_dump(30, 9, 100, 0);
    run_dump(20, 20, 100, 0);
    run_dump(18, 21, 50, 1);

    // abort in VALID with out_ready high: no handshake, no done
    @(negedge clk);
    first_addr = 5'd18;
    last_addr  = 5'd21;
    start      = 1'b1;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    saw_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || out_valid) saw_bad = 1;
    end
    chk("abort_quiet", 32'(saw_bad), 32'd0);

    // start and abort together in IDLE: nothing starts
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);

    // reset asserted during WAIT clears outputs asynchronously
    first_addr = 5'd5;
    last_addr  = 5'd10;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_busy", 32'(busy), 32'd0);
    run_dump(5, 10, 100, 0);

    // randomized register contents, ranges and back-pressure
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      run_dump(int'($urandom_range(31)), int'($urandom_range(31)), 60, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
